spi_axi_frame: RTL and testbench
================================

Name: spi_axi_frame

Overview:
- SPI slave frame decoder, oversampled in the AXI clock domain; sits directly upstream of the SPI-to-AXI-Lite master bridge.
- Deserialises SPI mode-0 frames into single-cycle write/read command pulses: 12-bit address, plus 32-bit data for writes.
- For reads, returns the bridge's read data on MISO after a dummy turnaround.
- Assumes aclk ≥ 8× SCK frequency.

Parameters:
- C_SYNC_STAGES, 2, flip-flop stages on spi_sck, spi_cs_n and spi_mosi (legal range 2..4).
- C_DUMMY_BITS, 8, SCK cycles between end of address and first read data bit (legal range 4..32).

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  synchronous, active-high reset.
- spi_sck  in  1  asynchronous SPI clock, idle low (mode 0).
- spi_cs_n  in  1  asynchronous chip select, active low.
- spi_mosi  in  1  asynchronous serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- axi_wr_addr  out  12  write address, held until the next write.
- axi_wr_data  out  32  write data, held until the next write.
- axi_wr_en  out  1  one-cycle write strobe.
- axi_rd_addr  out  12  read address, held until the next read.
- axi_rd_en  out  1  one-cycle read strobe.
- axi_rd_data  in  32  read result from the bridge.
- stat_spi_frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Synchronisation and edge detection:
  - All three SPI inputs pass through C_SYNC_STAGES flops.
  - Rising/falling SCK edges are detected from the last synchronised stage and its one-cycle delayed copy.
  - MOSI is sampled on SCK rising edges; MISO is updated on SCK falling edges.
- Frame format (first 16 bits):
  - bit15 = RnW (1 = read).
  - bits14:12 reserved, ignored.
  - bits11:0 = address.
- Write frame: 16 command bits followed by 32 data bits (48 total).
- Read frame: 16 command bits, then C_DUMMY_BITS dummy bits, then 32 data bits.
- FSM states: IDLE, CMD, WDATA, DUMMY, RDATA, DONE, WAIT_CS. A 6-bit bit counter counts rising edges within each phase.
- IDLE:
  - Synchronised CS low → CMD, counter cleared.
  - The falling edge of CS is not required; CS is sampled as a level.
- CMD:
  - On the 16th rising edge, branch on RnW: RnW = 0 → WDATA; RnW = 1 → DUMMY.
  - Entering DUMMY: axi_rd_addr is loaded and axi_rd_en pulses in the same cycle, exactly one cycle after the edge-detect cycle.
- WDATA:
  - On the 32nd rising edge, axi_wr_addr and axi_wr_data are loaded and axi_wr_en pulses in the same cycle → DONE.
- DUMMY:
  - spi_miso = 0 throughout.
  - On the C_DUMMY_BITS-th rising edge, axi_rd_data is captured into the 32-bit output shift register → RDATA.
  - The bridge must return read data within C_DUMMY_BITS SCK periods; this block does not check that.
- RDATA:
  - The first falling edge drives bit31; each subsequent falling edge shifts.
  - After the 32nd rising edge → DONE.
- DONE:
  - Further SCK edges are ignored; spi_miso = 0.
  - CS high → IDLE.
- Abort:
  - Synchronised CS high in CMD, WDATA, DUMMY or RDATA → IDLE.
  - stat_spi_frame_err pulses once; no axi_wr_en is issued.
  - A read whose axi_rd_en has already pulsed is not cancelled.
- spi_miso = 0 whenever CS is high.
- Reset:
  - All outputs are 0: addresses, axi_wr_data, strobes, spi_miso, stat.
  - The FSM goes to WAIT_CS; WAIT_CS → IDLE only once synchronised CS is high. A frame in progress at reset release is therefore ignored without an error pulse.
  - Reset mid-frame behaves identically.
- Strobes are never asserted in the same cycle as each other, and never more than one per frame.
- A rising SCK edge and CS going high in the same cycle: the CS abort takes priority and the edge is discarded.

Decomposition:
- Package spi_axi_pkg:
  - typedef enum for the FSM states.
  - Frame constants: C_CMD_BITS = 16, C_DATA_BITS = 32, RnW bit index = 15, address field width = 12.
- Sub-module spi_axi_sync: a parameterised N-stage synchroniser plus rising/falling edge detector, instantiated for SCK, CS and MOSI (edge outputs used for SCK only).

Test Plan:
- Write frame, cmd 0x0123 then data 0xCAFEBABE, SCK = aclk/10 → one axi_wr_en pulse with axi_wr_addr = 0x123 and axi_wr_data = 0xCAFEBABE; axi_rd_en never asserted.
- Read frame, cmd 0x8ABC, bench returns 0x12345678 three cycles after axi_rd_en → single axi_rd_en with axi_rd_addr = 0xABC; MISO shows 8 zero bits, then 0x12345678 MSB first, sampled on rising edges.
- CS raised after 20 bits of a write frame → stat_spi_frame_err pulses once; no axi_wr_en; the next complete write of 0x0001/0x00000001 succeeds normally.
- Write frame with 56 clocks (8 extra) → exactly one axi_wr_en, with data from the first 32 data bits; the extra bits are ignored.
- Reset asserted mid-read while CS stays low, then 10 more SCK edges → no strobes and no error pulse; after CS goes high, a new read of 0x8005 works.
- Back-to-back frames with minimum CS-high time of 4 aclk cycles (write 0x0010/0xFFFFFFFF, then read 0x8010) → both strobes occur, in order, with correct addresses.

Source files
------------

// File: rtl/spi_axi_pkg.sv
// Shared types and frame constants for the SPI slave frame decoder.
// Keeps the state encoding and field positions in one place for the decoder and its bench.
package spi_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_DUMMY,
      ST_RDATA,
      ST_DONE,
      ST_WAIT_CS
   } state_e;

   localparam int C_CMD_BITS  = 16;
   localparam int C_DATA_BITS = 32;
   localparam int C_RNW_BIT   = 15;
   localparam int C_ADDR_BITS = 12;

endpackage

// File: rtl/spi_axi_sync.sv
// N-stage synchroniser for one asynchronous input, with rising/falling edge
// detection taken from the last stage and its one-cycle delayed copy.
module spi_axi_sync #(
   parameter int C_STAGES = 2
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [C_STAGES-1:0] sync_q;
   logic                prev_q;

   // Reset to 0 so a chip select held low across reset never looks deselected.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[C_STAGES-2:0], d_i};
         prev_q <= sync_q[C_STAGES-1];
      end
   end

   assign q_o    = sync_q[C_STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_axi_frame.sv
// SPI mode-0 slave frame decoder oversampled in the AXI clock domain: turns
// command/data frames into single-cycle write/read pulses and serves read data on MISO.
module spi_axi_frame
   import spi_axi_pkg::*;
#(
   parameter int C_SYNC_STAGES = 2,
   parameter int C_DUMMY_BITS  = 8
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   spi_sck,
   input  logic                   spi_cs_n,
   input  logic                   spi_mosi,
   output logic                   spi_miso,
   output logic [C_ADDR_BITS-1:0] axi_wr_addr,
   output logic [C_DATA_BITS-1:0] axi_wr_data,
   output logic                   axi_wr_en,
   output logic [C_ADDR_BITS-1:0] axi_rd_addr,
   output logic                   axi_rd_en,
   input  logic [C_DATA_BITS-1:0] axi_rd_data,
   output logic                   stat_spi_frame_err
);

   localparam logic [5:0] C_LAST_CMD   = 6'(C_CMD_BITS - 1);
   localparam logic [5:0] C_LAST_DATA  = 6'(C_DATA_BITS - 1);
   localparam logic [5:0] C_LAST_DUMMY = 6'(C_DUMMY_BITS - 1);

   logic sck_rise, sck_fall, sck_s_unused;
   logic cs_s, cs_rise_unused, cs_fall_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_axi_sync #(.C_STAGES(C_SYNC_STAGES)) u_sync_sck (
      .clk_i(aclk), .srst_i(areset), .d_i(spi_sck),
      .q_o(sck_s_unused), .rise_o(sck_rise), .fall_o(sck_fall)
   );
   spi_axi_sync #(.C_STAGES(C_SYNC_STAGES)) u_sync_cs (
      .clk_i(aclk), .srst_i(areset), .d_i(spi_cs_n),
      .q_o(cs_s), .rise_o(cs_rise_unused), .fall_o(cs_fall_unused)
   );
   spi_axi_sync #(.C_STAGES(C_SYNC_STAGES)) u_sync_mosi (
      .clk_i(aclk), .srst_i(areset), .d_i(spi_mosi),
      .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
   );

   state_e                 state_q, state_d;
   logic [5:0]             cnt_q, cnt_d, cnt_inc;
   logic [C_DATA_BITS-1:0] sr_q, sr_d;
   logic [C_DATA_BITS-1:0] rd_sr_q, rd_sr_d;
   logic [C_ADDR_BITS-1:0] addr_q, addr_d;
   logic [C_ADDR_BITS-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [C_DATA_BITS-1:0] wr_data_q, wr_data_d;
   logic                   wr_en_q, wr_en_d, rd_en_q, rd_en_d;
   logic                   err_q, err_d, miso_q, miso_d;

   assign cnt_inc = cnt_q + 6'd1;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= ST_WAIT_CS;
         cnt_q     <= '0;
         sr_q      <= '0;
         rd_sr_q   <= '0;
         addr_q    <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         err_q     <= 1'b0;
         miso_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         rd_sr_q   <= rd_sr_d;
         addr_q    <= addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_addr_q <= rd_addr_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         err_q     <= err_d;
         miso_q    <= miso_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      rd_sr_d   = rd_sr_q;
      addr_d    = addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_addr_d = rd_addr_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      err_d     = 1'b0;
      miso_d    = 1'b0;
      case (state_q)
         ST_WAIT_CS: if (cs_s) state_d = ST_IDLE;
         ST_IDLE: begin
            if (!cs_s) begin
               state_d = ST_CMD;
               cnt_d   = '0;
            end
         end
         ST_DONE: if (cs_s) state_d = ST_IDLE;
         default: begin
            // Deselect wins over any SCK edge seen in the same cycle.
            if (cs_s) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               case (state_q)
                  ST_CMD: begin
                     if (sck_rise) begin
                        sr_d = {sr_q[C_DATA_BITS-2:0], mosi_s};
                        if (cnt_q == C_LAST_CMD) begin
                           cnt_d  = '0;
                           addr_d = {sr_q[C_ADDR_BITS-2:0], mosi_s};
                           if (sr_q[C_RNW_BIT-1]) begin
                              state_d   = ST_DUMMY;
                              rd_addr_d = {sr_q[C_ADDR_BITS-2:0], mosi_s};
                              rd_en_d   = 1'b1;
                           end else begin
                              state_d = ST_WDATA;
                           end
                        end else begin
                           cnt_d = cnt_inc;
                        end
                     end
                  end
                  ST_WDATA: begin
                     if (sck_rise) begin
                        sr_d = {sr_q[C_DATA_BITS-2:0], mosi_s};
                        if (cnt_q == C_LAST_DATA) begin
                           state_d   = ST_DONE;
                           wr_addr_d = addr_q;
                           wr_data_d = {sr_q[C_DATA_BITS-2:0], mosi_s};
                           wr_en_d   = 1'b1;
                        end else begin
                           cnt_d = cnt_inc;
                        end
                     end
                  end
                  ST_DUMMY: begin
                     if (sck_rise) begin
                        if (cnt_q == C_LAST_DUMMY) begin
                           state_d = ST_RDATA;
                           cnt_d   = '0;
                           rd_sr_d = axi_rd_data;
                        end else begin
                           cnt_d = cnt_inc;
                        end
                     end
                  end
                  ST_RDATA: begin
                     miso_d = miso_q;
                     if (sck_fall) begin
                        miso_d  = rd_sr_q[C_DATA_BITS-1];
                        rd_sr_d = {rd_sr_q[C_DATA_BITS-2:0], 1'b0};
                     end
                     if (sck_rise) begin
                        if (cnt_q == C_LAST_DATA) begin
                           state_d = ST_DONE;
                           miso_d  = 1'b0;
                        end else begin
                           cnt_d = cnt_inc;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   assign spi_miso           = miso_q;
   assign axi_wr_addr        = wr_addr_q;
   assign axi_wr_data        = wr_data_q;
   assign axi_wr_en          = wr_en_q;
   assign axi_rd_addr        = rd_addr_q;
   assign axi_rd_en          = rd_en_q;
   assign stat_spi_frame_err = err_q;

endmodule

// File: tb/tb_spi_axi_frame.sv
// Directed bench for spi_axi_frame: an SPI master drives frames, a frame-level model
// predicts the strobe sequence and MISO stream, and a monitor checks every strobe cycle.
module tb_spi_axi_frame;

   localparam int D = 8;
   localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ERR = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [11:0] addr;
      logic [31:0] data;
   } ev_t;

   logic        aclk = 1'b0;
   logic        areset, spi_sck, spi_cs_n, spi_mosi, spi_miso;
   logic [11:0] axi_wr_addr, axi_rd_addr;
   logic [31:0] axi_wr_data, axi_rd_data;
   logic        axi_wr_en, axi_rd_en, stat_spi_frame_err;

   always #5 aclk = ~aclk;

   spi_axi_frame #(.C_SYNC_STAGES(2), .C_DUMMY_BITS(D)) dut (
      .aclk(aclk), .areset(areset),
      .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data), .axi_wr_en(axi_wr_en),
      .axi_rd_addr(axi_rd_addr), .axi_rd_en(axi_rd_en), .axi_rd_data(axi_rd_data),
      .stat_spi_frame_err(stat_spi_frame_err)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   ev_t         exp_q[$];
   logic [11:0] m_wr_addr = '0, m_rd_addr = '0;
   logic [31:0] m_wr_data = '0;
   logic [63:0] cap_r = '0;
   logic [11:0] resp_addr;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, want);
   endtask

   // Bridge model: the data a read of a given address returns.
   function automatic logic [31:0] bridge_data(input logic [11:0] a);
      return (a == 12'hABC) ? 32'h12345678 : {20'h5A5A5, a};
   endfunction

   // Bridge stand-in: zero read data on the strobe, real data three cycles later.
   initial begin
      axi_rd_data = '0;
      forever begin
         @(negedge aclk);
         if (axi_rd_en === 1'b1) begin
            resp_addr   = axi_rd_addr;
            axi_rd_data = '0;
            repeat (3) @(posedge aclk);
            #1 axi_rd_data = bridge_data(resp_addr);
         end
      end
   end

   // Every strobe cycle must match the next predicted event, one strobe at a time.
   int  mon_n;
   ev_t mon_got, mon_want;
   always @(negedge aclk) begin
      mon_n = int'(axi_wr_en) + int'(axi_rd_en) + int'(stat_spi_frame_err);
      if (mon_n != 0) begin
         check("strobe_onehot", 64'(mon_n), 64'd1);
         mon_got.kind = axi_wr_en ? K_WR : (axi_rd_en ? K_RD : K_ERR);
         mon_got.addr = axi_wr_en ? axi_wr_addr : (axi_rd_en ? axi_rd_addr : 12'h0);
         mon_got.data = axi_wr_en ? axi_wr_data : 32'h0;
         if (exp_q.size() == 0) mon_want = '1;
         else mon_want = exp_q.pop_front();
         check("strobe_event", 64'(mon_got), 64'(mon_want));
         $display("strobe kind=%0d addr=%h data=%h", mon_got.kind, mon_got.addr, mon_got.data);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #2;
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      tick(5);
   endtask

   // Shift bits [63-first] .. [63-first-n+1]; MISO is sampled just before each rising edge.
   task automatic clock_bits(input logic [63:0] full, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         spi_mosi = full[63-i];
         tick(5);
         cap_r[63-i] = spi_miso;
         spi_sck = 1'b1;
         tick(5);
         spi_sck = 1'b0;
      end
   endtask

   task automatic cs_high(input int n);
      tick(5);
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      tick(n);
   endtask

   // Frame rules: 16 command bits, then 32 write bits or D dummy + 32 read bits.
   task automatic expect_frame(input logic [15:0] cmd, input logic [31:0] data, input int nbits);
      ev_t e;
      logic rnw;
      rnw = cmd[15];
      if (nbits >= 16 && rnw) begin
         e = '{kind: K_RD, addr: cmd[11:0], data: 32'h0};
         exp_q.push_back(e);
         m_rd_addr = cmd[11:0];
      end
      if (nbits >= 48 && !rnw) begin
         e = '{kind: K_WR, addr: cmd[11:0], data: data};
         exp_q.push_back(e);
         m_wr_addr = cmd[11:0];
         m_wr_data = data;
      end
      if (rnw ? (nbits < 16 + D + 32) : (nbits < 48)) begin
         e = '{kind: K_ERR, addr: 12'h0, data: 32'h0};
         exp_q.push_back(e);
      end
   endtask

   task automatic run_frame(input logic [15:0] cmd, input logic [47:0] payload,
                            input int nbits, input int gap);
      expect_frame(cmd, payload[47:16], nbits);
      cs_low();
      clock_bits({cmd, payload}, 0, nbits);
      cs_high(gap);
      $display("frame cmd=%h bits=%0d", cmd, nbits);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_wr_addr"}, 64'(axi_wr_addr), 64'(m_wr_addr));
      check({tag, "_wr_data"}, 64'(axi_wr_data), 64'(m_wr_data));
      check({tag, "_rd_addr"}, 64'(axi_rd_addr), 64'(m_rd_addr));
      check({tag, "_miso_idle"}, 64'(spi_miso), 64'd0);
   endtask

   initial begin
      areset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
      tick(5);
      check("rst_wr_addr", 64'(axi_wr_addr), 64'd0);
      check("rst_wr_data", 64'(axi_wr_data), 64'd0);
      check("rst_wr_en", 64'(axi_wr_en), 64'd0);
      check("rst_rd_addr", 64'(axi_rd_addr), 64'd0);
      check("rst_rd_en", 64'(axi_rd_en), 64'd0);
      check("rst_miso", 64'(spi_miso), 64'd0);
      check("rst_err", 64'(stat_spi_frame_err), 64'd0);
      areset = 1'b0;
      tick(5);

      // Plain write.
      run_frame(16'h0123, {32'hCAFEBABE, 16'h0}, 48, 10);
      check_state("wr1");
      check("wr1_addr_lit", 64'(axi_wr_addr), 64'h123);
      check("wr1_data_lit", 64'(axi_wr_data), 64'hCAFEBABE);

      // Plain read: D zero bits then the bridge data, MSB first.
      run_frame(16'h8ABC, 48'h0, 16 + D + 32, 10);
      check_state("rd1");
      check("rd1_addr_lit", 64'(axi_rd_addr), 64'hABC);
      check("rd1_miso_lit", 64'(cap_r[47:8]), {24'h0, 8'h00, 32'h12345678});

      // Aborted write after 20 bits, then a clean write.
      run_frame(16'h0456, {32'hDEADBEEF, 16'h0}, 20, 10);
      check_state("abort");
      run_frame(16'h0001, {32'h00000001, 16'h0}, 48, 10);
      check_state("wr2");
      check("wr2_data_lit", 64'(axi_wr_data), 64'h1);

      // Eight surplus clocks after a complete write are ignored.
      run_frame(16'h0222, {32'h13579BDF, 16'hFF00}, 56, 10);
      check_state("extra");
      check("extra_data_lit", 64'(axi_wr_data), 64'h13579BDF);

      // Reset in the middle of a read with CS held low, then more clocks.
      cs_low();
      clock_bits({16'h8005, 48'h0}, 0, 10);
      areset = 1'b1;
      tick(3);
      m_wr_addr = '0; m_wr_data = '0; m_rd_addr = '0;
      areset = 1'b0;
      clock_bits({16'h8005, 48'h0}, 10, 10);
      cs_high(10);
      $display("frame cmd=8005 reset mid-frame");
      check_state("midrst");
      run_frame(16'h8005, 48'h0, 16 + D + 32, 10);
      check_state("rd2");
      check("rd2_miso", 64'(cap_r[47:8]), {24'h0, 8'h00, bridge_data(12'h005)});

      // Back-to-back frames with a four-cycle deselect gap.
      run_frame(16'h0010, {32'hFFFFFFFF, 16'h0}, 48, 4);
      run_frame(16'h8010, 48'h0, 16 + D + 32, 10);
      check_state("b2b");
      check("b2b_rd_addr_lit", 64'(axi_rd_addr), 64'h010);
      check("b2b_wr_data_lit", 64'(axi_wr_data), 64'hFFFFFFFF);
      check("b2b_miso", 64'(cap_r[47:8]), {24'h0, 8'h00, bridge_data(12'h010)});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
